// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: memory write codes, read cuts
// and FSM state encoding.
package dm_arbiter_pkg;

    localparam logic [2:0] MW_READ = 3'd0;
    localparam logic [2:0] MW_WORD = 3'd1;
    localparam logic [2:0] MW_BYTE = 3'd2;
    localparam logic [2:0] MW_ATOM = 3'd3;
    localparam logic [2:0] MW_HALF = 3'd4;

    localparam logic [1:0] CUT_WORD = 2'd0;
    localparam logic [1:0] CUT_BYTE = 2'd1;
    localparam logic [1:0] CUT_HALF = 2'd2;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } dm_state_e;

    // Codes above MW_HALF have no memory meaning and must never be issued.
    function automatic logic dm_op_legal(input logic [2:0] op);
        return op <= MW_HALF;
    endfunction

endpackage

// File: rtl/dm_rr_pick.sv
// Two-way round-robin selector: a lone requester wins, on a tie the port other
// than the last winner wins.
module dm_rr_pick (
    input  logic req0_i,
    input  logic req1_i,
    input  logic rr_i,
    output logic valid_o,
    output logic winner_o
);

    always_comb begin
        valid_o  = req0_i | req1_i;
        winner_o = (req0_i & req1_i) ? ~rr_i : req1_i;
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter and sequencer in front of the single-ported data memory.
// Each transaction runs IDLE -> ACCESS -> DONE, acknowledging the owner in DONE.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 32
) (
    input  logic          Clk,
    input  logic          Reset_n,

    input  logic          Req0,
    input  logic [2:0]    Op0,
    input  logic [AW-1:0] Ad0,
    input  logic [31:0]   WrData0,
    input  logic [1:0]    Cut0,
    output logic          Ack0,
    output logic          Err0,
    output logic [31:0]   RdData0,

    input  logic          Req1,
    input  logic [2:0]    Op1,
    input  logic [AW-1:0] Ad1,
    input  logic [31:0]   WrData1,
    input  logic [1:0]    Cut1,
    output logic          Ack1,
    output logic          Err1,
    output logic [31:0]   RdData1,

    output logic [AW-1:0] Mem_Ad,
    output logic [31:0]   Mem_WrData,
    output logic [2:0]    Mem_MemWr,
    output logic [1:0]    Mem_Cut,
    input  logic [31:0]   Mem_DM,

    output logic          Busy,
    output logic          Owner
);

    dm_state_e     state_q, state_d;
    logic          rr_q, rr_d;
    logic          owner_q, owner_d;
    logic [AW-1:0] ad_q, ad_d;
    logic [31:0]   wd_q, wd_d;
    logic [1:0]    cut_q, cut_d;
    logic [2:0]    op_q, op_d;
    logic          bad_q, bad_d;
    logic [2:0]    memwr_q, memwr_d;
    logic [1:0]    ack_q, ack_d;
    logic [1:0]    err_q, err_d;
    logic          busy_q, busy_d;

    logic          pick_valid;
    logic          pick_winner;
    logic [2:0]    sel_op;
    logic [AW-1:0] sel_ad;
    logic [31:0]   sel_wd;
    logic [1:0]    sel_cut;
    logic          sel_bad;
    logic          rd_ok;

    dm_rr_pick u_rr_pick (
        .req0_i   (Req0),
        .req1_i   (Req1),
        .rr_i     (rr_q),
        .valid_o  (pick_valid),
        .winner_o (pick_winner)
    );

    // Full-width compare: out-of-range addresses are rejected, never wrapped.
    always_comb begin
        sel_op  = pick_winner ? Op1 : Op0;
        sel_ad  = pick_winner ? Ad1 : Ad0;
        sel_wd  = pick_winner ? WrData1 : WrData0;
        sel_cut = pick_winner ? Cut1 : Cut0;
        sel_bad = !dm_op_legal(sel_op) || (sel_ad >= AW'(DEPTH));
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        ad_d    = ad_q;
        wd_d    = wd_q;
        cut_d   = cut_q;
        op_d    = op_q;
        bad_d   = bad_q;
        memwr_d = MW_READ;
        ack_d   = 2'b00;
        err_d   = 2'b00;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StAccess;
                    owner_d = pick_winner;
                    rr_d    = pick_winner;
                    op_d    = sel_op;
                    ad_d    = sel_ad;
                    wd_d    = sel_wd;
                    cut_d   = sel_cut;
                    bad_d   = sel_bad;
                    // Write code is live only during ACCESS; a bad request reads harmlessly.
                    memwr_d = sel_bad ? MW_READ : sel_op;
                end
            end
            StAccess: begin
                state_d        = StDone;
                ack_d[owner_q] = 1'b1;
                err_d[owner_q] = bad_q;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            ad_q    <= '0;
            wd_q    <= '0;
            cut_q   <= '0;
            op_q    <= MW_READ;
            bad_q   <= 1'b0;
            memwr_q <= MW_READ;
            ack_q   <= 2'b00;
            err_q   <= 2'b00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            ad_q    <= ad_d;
            wd_q    <= wd_d;
            cut_q   <= cut_d;
            op_q    <= op_d;
            bad_q   <= bad_d;
            memwr_q <= memwr_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Memory data is already registered, so only the Ack gating is combinational.
    assign rd_ok   = (op_q == MW_READ) && !bad_q;
    assign RdData0 = (ack_q[0] && rd_ok) ? Mem_DM : 32'h0;
    assign RdData1 = (ack_q[1] && rd_ok) ? Mem_DM : 32'h0;

    assign Ack0       = ack_q[0];
    assign Ack1       = ack_q[1];
    assign Err0       = err_q[0];
    assign Err1       = err_q[1];
    assign Mem_Ad     = ad_q;
    assign Mem_WrData = wd_q;
    assign Mem_MemWr  = memwr_q;
    assign Mem_Cut    = cut_q;
    assign Busy       = busy_q;
    assign Owner      = owner_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter with a behavioural data memory attached.
module tb_dm_arbiter;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 32;

    logic          Clk     = 1'b0;
    logic          Reset_n = 1'b0;
    logic          Req0 = 1'b0, Req1 = 1'b0;
    logic [2:0]    Op0 = '0, Op1 = '0;
    logic [AW-1:0] Ad0 = '0, Ad1 = '0;
    logic [31:0]   WrData0 = '0, WrData1 = '0;
    logic [1:0]    Cut0 = '0, Cut1 = '0;
    logic          Ack0, Ack1, Err0, Err1;
    logic [31:0]   RdData0, RdData1;
    logic [AW-1:0] Mem_Ad;
    logic [31:0]   Mem_WrData;
    logic [2:0]    Mem_MemWr;
    logic [1:0]    Mem_Cut;
    logic [31:0]   Mem_DM = '0;
    logic          Busy, Owner;

    always #5 Clk = ~Clk;

    dm_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Req0       (Req0),
        .Op0        (Op0),
        .Ad0        (Ad0),
        .WrData0    (WrData0),
        .Cut0       (Cut0),
        .Ack0       (Ack0),
        .Err0       (Err0),
        .RdData0    (RdData0),
        .Req1       (Req1),
        .Op1        (Op1),
        .Ad1        (Ad1),
        .WrData1    (WrData1),
        .Cut1       (Cut1),
        .Ack1       (Ack1),
        .Err1       (Err1),
        .RdData1    (RdData1),
        .Mem_Ad     (Mem_Ad),
        .Mem_WrData (Mem_WrData),
        .Mem_MemWr  (Mem_MemWr),
        .Mem_Cut    (Mem_Cut),
        .Mem_DM     (Mem_DM),
        .Busy       (Busy),
        .Owner      (Owner)
    );

    // Behavioural single-port memory: writes low lanes for byte/half, registered cut read.
    logic [31:0] mem [DEPTH] = '{default: 32'h0};
    logic [31:0] rd_word;

    always_comb rd_word = (Mem_Ad < DEPTH) ? mem[Mem_Ad[5:0]] : 32'h0;

    always @(posedge Clk) begin
        if (Mem_Ad < DEPTH) begin
            case (Mem_MemWr)
                3'd1, 3'd3: mem[Mem_Ad[5:0]]        <= Mem_WrData;
                3'd2:       mem[Mem_Ad[5:0]][7:0]   <= Mem_WrData[7:0];
                3'd4:       mem[Mem_Ad[5:0]][15:0]  <= Mem_WrData[15:0];
                default: ;
            endcase
        end
        case (Mem_Cut)
            2'd1:    Mem_DM <= {24'h0, rd_word[7:0]};
            2'd2:    Mem_DM <= {16'h0, rd_word[15:0]};
            default: Mem_DM <= rd_word;
        endcase
    end

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rd;
        int          wr_cnt;
        logic [2:0]  wr_code;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_txn(input int port, input logic err, input logic [31:0] rd,
                              input int wc, input logic [2:0] code);
        exp_t e;
        e.port    = port;
        e.err     = err;
        e.rd      = rd;
        e.wr_cnt  = wc;
        e.wr_code = code;
        q.push_back(e);
    endtask

    // Requester: present fields, hold Req until Ack, drop it on the edge ending Ack.
    task automatic txn(input int p, input logic [2:0] op, input logic [31:0] ad,
                       input logic [31:0] wd, input logic [1:0] cut);
        bit got;
        got = 1'b0;
        if (p == 0) begin
            Op0 = op; Ad0 = ad; WrData0 = wd; Cut0 = cut; Req0 = 1'b1;
        end else begin
            Op1 = op; Ad1 = ad; WrData1 = wd; Cut1 = cut; Req1 = 1'b1;
        end
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge Clk);
            got = (p == 0) ? Ack0 : Ack1;
        end
        if (!got) check("ack_timeout", 32'h0, 32'h1);
        @(posedge Clk);
        #1;
        if (p == 0) Req0 = 1'b0;
        else        Req1 = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  {31'h0, Busy}, 32'h0);
        check({tag, "_owner"}, {31'h0, Owner}, 32'h0);
        check({tag, "_ad"},    Mem_Ad, 32'h0);
        check({tag, "_wd"},    Mem_WrData, 32'h0);
        check({tag, "_memwr"}, {29'h0, Mem_MemWr}, 32'h0);
        check({tag, "_cut"},   {30'h0, Mem_Cut}, 32'h0);
        check({tag, "_ackerr"}, {28'h0, Ack0, Ack1, Err0, Err1}, 32'h0);
        check({tag, "_rddata"}, RdData0 | RdData1, 32'h0);
    endtask

    // Monitor: pops one expectation per Ack and checks the write activity since the last Ack.
    int         cyc      = 0;
    int         wr_cnt   = 0;
    logic [2:0] wr_code  = '0;
    int         last_ack = -1;
    bit         gap_chk  = 1'b0;
    exp_t       mon_e;
    int         mon_p;

    always @(negedge Clk) begin
        cyc++;
        if (!Reset_n) begin
            wr_cnt = 0;
        end else begin
            if (Mem_MemWr != 3'd0) begin
                wr_cnt++;
                wr_code = Mem_MemWr;
            end
            if (Ack0 || Ack1) begin
                check("ack_overlap", {31'h0, Ack0 & Ack1}, 32'h0);
                mon_p = Ack1 ? 1 : 0;
                if (q.size() == 0) begin
                    check("unexpected_ack", 32'h1, 32'h0);
                end else begin
                    mon_e = q.pop_front();
                    check("ack_port", 32'(mon_p), 32'(mon_e.port));
                    check("owner", {31'h0, Owner}, 32'(mon_e.port));
                    check("busy_in_done", {31'h0, Busy}, 32'h1);
                    check("err", {31'h0, (mon_p == 1) ? Err1 : Err0}, {31'h0, mon_e.err});
                    check("rddata", (mon_p == 1) ? RdData1 : RdData0, mon_e.rd);
                    check("rddata_other", (mon_p == 1) ? RdData0 : RdData1, 32'h0);
                    check("wr_cycles", 32'(wr_cnt), 32'(mon_e.wr_cnt));
                    if (mon_e.wr_cnt > 0) check("wr_code", {29'h0, wr_code}, {29'h0, mon_e.wr_code});
                end
                if (gap_chk && last_ack >= 0) check("ack_spacing", 32'(cyc - last_ack), 32'd3);
                last_ack = cyc;
                wr_cnt   = 0;
            end else if (Err0 || Err1) begin
                check("err_without_ack", 32'h1, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        check_reset_outputs("reset");
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        check("idle_busy", {31'h0, Busy}, 32'h0);

        // Abandon a write mid-ACCESS with an asynchronous reset.
        Op0 = 3'd1; Ad0 = 32'd7; WrData0 = 32'h12345678; Cut0 = 2'd0; Req0 = 1'b1;
        @(posedge Clk);
        #2;
        check("grant_busy", {31'h0, Busy}, 32'h1);
        check("grant_memwr", {29'h0, Mem_MemWr}, 32'h1);
        check("grant_ad", Mem_Ad, 32'd7);
        Reset_n = 1'b0;
        #1;
        check_reset_outputs("async");
        Req0 = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        repeat (6) @(posedge Clk);
        #1;
        check("post_reset_busy", {31'h0, Busy}, 32'h0);

        // Abandoned write must not have reached word 7.
        expect_txn(0, 1'b0, 32'h0,        0, 3'd0); txn(0, 3'd0, 32'd7, 32'h0, 2'd0);
        expect_txn(0, 1'b0, 32'h0,        1, 3'd1); txn(0, 3'd1, 32'd5, 32'hDEADBEEF, 2'd0);
        expect_txn(0, 1'b0, 32'hDEADBEEF, 0, 3'd0); txn(0, 3'd0, 32'd5, 32'h0, 2'd0);
        expect_txn(1, 1'b0, 32'h0,        1, 3'd2); txn(1, 3'd2, 32'd5, 32'h00000011, 2'd0);
        expect_txn(1, 1'b0, 32'h00000011, 0, 3'd0); txn(1, 3'd0, 32'd5, 32'h0, 2'd1);
        expect_txn(1, 1'b0, 32'h0000BE11, 0, 3'd0); txn(1, 3'd0, 32'd5, 32'h0, 2'd2);
        expect_txn(1, 1'b0, 32'hDEADBE11, 0, 3'd0); txn(1, 3'd0, 32'd5, 32'h0, 2'd3);
        expect_txn(0, 1'b0, 32'h0,        1, 3'd4); txn(0, 3'd4, 32'd6, 32'hCAFEF00D, 2'd0);
        expect_txn(0, 1'b0, 32'h0000F00D, 0, 3'd0); txn(0, 3'd0, 32'd6, 32'h0, 2'd0);
        expect_txn(1, 1'b0, 32'h0,        1, 3'd3); txn(1, 3'd3, 32'd7, 32'hA5A5A5A5, 2'd0);
        expect_txn(1, 1'b0, 32'hA5A5A5A5, 0, 3'd0); txn(1, 3'd0, 32'd7, 32'h0, 2'd0);

        // Fresh reset so rr=0 and the first contended grant goes to port 1.
        @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        check("rr_reset_owner", {31'h0, Owner}, 32'h0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        expect_txn(1, 1'b0, 32'h0,        1, 3'd1);
        expect_txn(0, 1'b0, 32'h0,        1, 3'd1);
        expect_txn(1, 1'b0, 32'h02020202, 0, 3'd0);
        expect_txn(0, 1'b0, 32'h01010101, 0, 3'd0);
        last_ack = -1;
        gap_chk  = 1'b1;
        fork
            begin
                txn(1, 3'd1, 32'd2, 32'h02020202, 2'd0);
                txn(1, 3'd0, 32'd2, 32'h0, 2'd0);
            end
            begin
                txn(0, 3'd1, 32'd1, 32'h01010101, 2'd0);
                txn(0, 3'd0, 32'd1, 32'h0, 2'd0);
            end
        join
        gap_chk = 1'b0;

        // Range checks: no truncation of 64 or 0x80000000 onto word 0; 63 is legal.
        expect_txn(0, 1'b0, 32'h0,        1, 3'd1); txn(0, 3'd1, 32'd0, 32'h5A5A5A5A, 2'd0);
        expect_txn(0, 1'b1, 32'h0,        0, 3'd0); txn(0, 3'd1, 32'd64, 32'hFFFFFFFF, 2'd0);
        expect_txn(0, 1'b1, 32'h0,        0, 3'd0); txn(0, 3'd1, 32'h80000000, 32'hFFFFFFFF, 2'd0);
        expect_txn(0, 1'b1, 32'h0,        0, 3'd0); txn(0, 3'd0, 32'd64, 32'h0, 2'd0);
        expect_txn(0, 1'b0, 32'h0,        1, 3'd1); txn(0, 3'd1, 32'd63, 32'h63636363, 2'd0);
        expect_txn(0, 1'b0, 32'h63636363, 0, 3'd0); txn(0, 3'd0, 32'd63, 32'h0, 2'd0);
        expect_txn(0, 1'b0, 32'h5A5A5A5A, 0, 3'd0); txn(0, 3'd0, 32'd0, 32'h0, 2'd0);

        // Illegal ops never write and report an error with zero read data.
        expect_txn(1, 1'b0, 32'h0,        1, 3'd1); txn(1, 3'd1, 32'd3, 32'h33333333, 2'd0);
        expect_txn(1, 1'b1, 32'h0,        0, 3'd0); txn(1, 3'd6, 32'd3, 32'hFFFFFFFF, 2'd0);
        expect_txn(1, 1'b1, 32'h0,        0, 3'd0); txn(1, 3'd5, 32'd3, 32'hFFFFFFFF, 2'd0);
        expect_txn(1, 1'b1, 32'h0,        0, 3'd0); txn(1, 3'd7, 32'd3, 32'hFFFFFFFF, 2'd0);
        expect_txn(1, 1'b0, 32'h33333333, 0, 3'd0); txn(1, 3'd0, 32'd3, 32'h0, 2'd0);

        repeat (5) @(posedge Clk);
        #1;
        check("final_busy", {31'h0, Busy}, 32'h0);
        check("queue_empty", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
